corescore_emitter_uart: RTL and testbench
=========================================

# corescore_emitter_uart

Transmit-only 8N1 UART serializer with a valid/ready byte input, used by the SoC as its memory-mapped character output. A byte accepted on the handshake is shifted out LSB-first on `o_uart_tx` at a bit period derived from the clock frequency and baud rate parameters. It sits beside the clock divider in the SoC and is fed directly from the CPU store data bus; the `UART_CNTL` status register reports `!o_ready` as its busy bit.

## Interface
- `clk_freq_hz`, default 12000000 — frequency of `i_clk` in Hz.
- `baud_rate`, default 57600 — line rate in bits/s.
- `i_clk`  in  1  — sole clock. One clock; reset is asynchronous and active-high.
- `i_rst`  in  1  — asynchronous, active-high reset.
- `i_data`  in  8  — byte to send; sampled only on an accepted handshake.
- `i_valid`  in  1  — source offers `i_data`.
- `o_ready`  out  1  — emitter can accept a byte this cycle.
- `o_uart_tx`  out  1  — serial line; idle high.

## Operation
- `DIV = clk_freq_hz / baud_rate` (integer division, truncating). Example: 615000/56000 gives 10. `DIV < 2` is a static elaboration error.
- Baud counter width is `$clog2(DIV)`.
- Frame is 10 bits: start (0), data[0]…data[7], stop (1). No parity.
- A handshake happens at a rising edge where `i_valid && o_ready`. If `i_valid` is high while `o_ready` is low, it has no effect and nothing is queued. The source holds `i_valid` and `i_data` until accepted.
- States:
  - IDLE: `o_ready=1`, `tx=1`. On handshake, load the 10-bit shift register, set `tx=0` and go to SEND.
  - SEND: each bit is held for exactly DIV cycles. On the baud tick, shift right with fill 1. After the 10th bit (stop bit) completes, go to IDLE.
- Reset, including mid-frame: abort immediately. `o_uart_tx=1`, `o_ready=1`, counters 0, state IDLE. A partially sent frame is not resumed.

## Timing
- Reset values: `o_uart_tx=1`, `o_ready=1`.
- Handshake at edge E0:
  - Start bit drives the line from after E0 for DIV cycles.
  - Data bit k occupies [E0+(k+1)·DIV, E0+(k+2)·DIV).
  - Stop bit occupies [E0+9·DIV, E0+10·DIV).
- `o_ready` drops right after E0 and rises at edge E0+10·DIV. The next handshake can occur at that edge, so back-to-back frames have no idle gap.
- `o_uart_tx` is a registered output (glitch-free).

## Configuration
- `CORESCORE_EMITTER_UART_BUFFER_EN` defined:
  - Adds a one-byte holding register. `o_ready` means the holding register is empty.
  - A handshake loads the holding register. The idle shifter takes it on the following edge, so the start bit begins one cycle later than in unbuffered mode.
  - While a frame is shifting, one more byte can be accepted. It starts immediately after the current stop bit, with no gap.
  - After reset, `o_ready=1`.
- Macro undefined: unbuffered behaviour exactly as in Timing above.

## Structure
- Shared package `corescore_uart_pkg`:
  - `UART_FRAME_BITS=10`
  - `UART_START_BIT=1'b0`
  - `UART_STOP_BIT=1'b1`
  - function `uart_div(clk_hz, baud)`
- One sub-module: `emitter_uart_baud_tick`. It takes a DIV parameter and a `restart` input, and pulses `tick` every DIV cycles while enabled.
- The top module holds the state machine, shift register, bit counter and the optional holding register.

## Test plan
1. Assert `i_rst` mid-frame, then release it → `o_uart_tx=1` and `o_ready=1` on the same cycle as assertion; the line stays idle afterwards.
2. With `clk_freq_hz=615000` and `baud_rate=56000` (DIV=10), send 0x55 → line reads 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles; `o_ready` is low for exactly 100 cycles.
3. Send 0x80 and then 0x01 back-to-back with `i_valid` held high → 200 contiguous cycles of two frames; the second start bit follows the first stop bit with no extra idle cycle.
4. Pulse `i_valid` with 0xFF while `o_ready=0` → the byte is ignored; the line carries only the current frame.
5. With `clk_freq_hz=100` and `baud_rate=40` (DIV=2), send 0xA3 → each bit lasts 2 cycles; LSB-first pattern 0,1,1,0,0,0,1,0,1,1.
6. With `BUFFER_EN` defined, issue three handshakes with no waits → the second is accepted during frame 1, the third waits until frame 2 starts, and all three frames are contiguous.

Source files
------------

// File: rtl/corescore_uart_pkg.sv
// ============================================================================
// Module      : corescore_uart_pkg
// Description : Shared constants, state type and divider helper for the
//               corescore character-output UART.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package corescore_uart_pkg;

  // One 8N1 frame: start bit, eight data bits LSB first, one stop bit.
  localparam int   UART_FRAME_BITS = 10;
  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;

  // Emitter shifter state.
  typedef enum logic [0:0] {
    UART_IDLE = 1'b0,
    UART_SEND = 1'b1
  } uart_state_t;

  // Clock cycles per bit; the fraction is truncated.
  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/corescore_emitter_uart_baud_tick.sv
// ============================================================================
// Module      : emitter_uart_baud_tick
// Description : Bit-period timer. Pulses o_tick for one cycle every DIV
//               cycles while i_en is high; i_restart re-aligns the period
//               to the cycle after it is seen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module emitter_uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);

  // Guarded so an illegal DIV still elaborates far enough to hit the top's check.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CNT_LAST);

  // Free-running modulo-DIV counter; cleared on restart and at each tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/corescore_emitter.sv
// ============================================================================
// Module      : corescore_emitter_uart
// Description : Transmit-only 8N1 UART with a valid/ready byte input.
//               Optional one-byte holding register enabled by the macro
//               CORESCORE_EMITTER_UART_BUFFER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module corescore_emitter_uart
  import corescore_uart_pkg::*;
#(
  parameter int clk_freq_hz = 12000000,
  parameter int baud_rate   = 57600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_uart_tx
);

  localparam int         DIV      = uart_div(clk_freq_hz, baud_rate);
  localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("corescore_emitter_uart: clk_freq_hz/baud_rate must be at least 2");
    end
  endgenerate

  uart_state_t                r_state;
  logic [UART_FRAME_BITS-1:0] r_shift;
  logic [3:0]                 r_bitcnt;
  logic                       r_tx;

  logic       w_tick;
  logic       w_send;
  logic       w_last;
  logic       w_load;
  logic [7:0] w_load_data;
  logic       w_unused_shift0;

  assign w_send    = (r_state == UART_SEND);
  // Final tick of the stop bit: the shifter is free from the next edge on.
  assign w_last    = w_send && w_tick && (r_bitcnt == LAST_BIT);
  // Bit 0 is the start bit, already on the line when the frame is loaded.
  assign w_unused_shift0 = r_shift[0];
  assign o_uart_tx = r_tx;

`ifdef CORESCORE_EMITTER_UART_BUFFER_EN
  logic       r_hold_valid;
  logic [7:0] r_hold;

  // Ready means the holding register is empty.
  assign o_ready     = !r_hold_valid;
  assign w_load      = r_hold_valid && (!w_send || w_last);
  assign w_load_data = r_hold;

  // Holding register: filled by the handshake, drained into the shifter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
    end else if (i_valid && o_ready) begin
      r_hold       <= i_data;
      r_hold_valid <= 1'b1;
    end else if (w_load) begin
      r_hold_valid <= 1'b0;
    end
  end
`else
  // Also ready during the last stop-bit cycle so frames can abut.
  assign o_ready     = !w_send || w_last;
  assign w_load      = i_valid && o_ready;
  assign w_load_data = i_data;
`endif

  emitter_uart_baud_tick #(
    .DIV(DIV)
  ) u_baud (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_send),
    .i_restart(w_load),
    .o_tick   (w_tick)
  );

  // Frame FSM: load puts the start bit on the line, each tick shifts one bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= UART_IDLE;
      r_shift  <= '1;
      r_bitcnt <= '0;
      r_tx     <= UART_STOP_BIT;
    end else if (w_load) begin
      r_state  <= UART_SEND;
      r_shift  <= {UART_STOP_BIT, w_load_data, UART_START_BIT};
      r_bitcnt <= '0;
      r_tx     <= UART_START_BIT;
    end else if (w_send && w_tick) begin
      if (w_last) begin
        r_state  <= UART_IDLE;
        r_shift  <= '1;
        r_bitcnt <= '0;
        r_tx     <= UART_STOP_BIT;
      end else begin
        r_shift  <= {1'b1, r_shift[UART_FRAME_BITS-1:1]};
        r_tx     <= r_shift[1];
        r_bitcnt <= r_bitcnt + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_corescore_emitter_uart.sv
// ============================================================================
// Module      : tb_corescore_emitter_uart
// Description : Self-checking bench for corescore_emitter_uart (DIV=10 and
//               DIV=2 instances). Honours CORESCORE_EMITTER_UART_BUFFER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_corescore_emitter_uart;

  typedef logic [7:0] bq_t[$];

  localparam int DIV1 = 615000 / 56000;
  localparam int DIV2 = 100 / 40;
`ifdef CORESCORE_EMITTER_UART_BUFFER_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic [7:0] data2 = 8'h00;
  logic       valid1 = 1'b0;
  logic       valid2 = 1'b0;
  logic       rdy1, rdy2, tx1, tx2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  corescore_emitter_uart #(.clk_freq_hz(615000), .baud_rate(56000)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data1), .i_valid(valid1),
    .o_ready(rdy1), .o_uart_tx(tx1)
  );

  corescore_emitter_uart #(.clk_freq_hz(100), .baud_rate(40)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(data2), .i_valid(valid2),
    .o_ready(rdy2), .o_uart_tx(tx2)
  );

  function automatic logic get_tx(input int sel);
    return (sel != 0) ? tx2 : tx1;
  endfunction

  function automatic logic get_rdy(input int sel);
    return (sel != 0) ? rdy2 : rdy1;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel != 0) begin valid2 = v; data2 = d; end
    else begin valid1 = v; data1 = d; end
  endtask

  // Expected line level p cycles after the first start bit, frames abutting.
  function automatic logic model_line(input bq_t bytes, input int div, input int p);
    int f, b;
    logic [7:0] d;
    if (p < 0) return 1'b1;
    f = p / (10 * div);
    if (f >= bytes.size()) return 1'b1;
    d = bytes[f];
    b = (p % (10 * div)) / div;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // Expected handshake edge of byte j relative to the first handshake,
  // with the source holding valid continuously.
  function automatic int model_hs(input int j, input int div);
`ifdef CORESCORE_EMITTER_UART_BUFFER_EN
    return (j == 0) ? 0 : (j - 1) * 10 * div + 2;
`else
    return j * 10 * div;
`endif
  endfunction

  // Offer bytes with valid held, log the line and handshake edges, then check.
  task automatic run_stream(input string name, input int sel, input bq_t bytes);
    bq_t  q;
    int   hs[$];
    logic samp[$];
    int   n, e0, ncyc, div, badi;
    logic r0, want, got, gotb, wantb;
    div  = (sel != 0) ? DIV2 : DIV1;
    ncyc = LAT + bytes.size() * 10 * div + 6;
    q = bytes; n = 0; e0 = -1; r0 = 1'b1;
    forever begin
      @(negedge clk);
      samp.push_back(get_tx(sel));
      if (n == e0) r0 = get_rdy(sel);
      if (q.size() > 0) begin
        drive(sel, 1'b1, q[0]);
        if (get_rdy(sel)) begin
          hs.push_back(n + 1);
          if (e0 < 0) e0 = n + 1;
          void'(q.pop_front());
        end
      end else begin
        drive(sel, 1'b0, 8'($urandom));
      end
      n++;
      if (e0 >= 0 && q.size() == 0 && n >= e0 + ncyc) break;
      if (n > 20000) break;
    end
    checks++;
    if (e0 < 0 || q.size() != 0) begin
      errors++;
      $display("FAIL %s handshake timeout: accepted=%0d required=%0d", name, hs.size(), bytes.size());
      return;
    end
    badi = -1; gotb = 1'b0; wantb = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      got  = samp[e0 + i];
      want = model_line(bytes, div, i - LAT);
      if (got !== want && badi < 0) begin badi = i; gotb = got; wantb = want; end
    end
    if (badi >= 0) begin
      errors++;
      $display("FAIL %s line: cycle %0d tx=%b required=%b", name, badi, gotb, wantb);
    end
    for (int j = 1; j < hs.size(); j++) begin
      checks++;
      if (hs[j] - e0 !== model_hs(j, div)) begin
        errors++;
        $display("FAIL %s handshake %0d: edge %0d required %0d", name, j, hs[j] - e0, model_hs(j, div));
      end
    end
    checks++;
    if (r0 !== 1'b0) begin
      errors++;
      $display("FAIL %s ready after accept: got %b required 0", name, r0);
    end
    checks++;
    if (get_rdy(sel) !== 1'b1) begin
      errors++;
      $display("FAIL %s ready at end: got %b required 1", name, get_rdy(sel));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (tx1 !== 1'b1)  begin errors++; $display("FAIL reset tx1: got %b required 1", tx1); end
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset ready1: got %b required 1", rdy1); end
    if (tx2 !== 1'b1)  begin errors++; $display("FAIL reset tx2: got %b required 1", tx2); end
    if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset ready2: got %b required 1", rdy2); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_55();
    bq_t b;
    b.push_back(8'h55);
    run_stream("frame_55", 0, b);
  endtask

  task automatic test_back_to_back();
    bq_t b;
    b.push_back(8'h80);
    b.push_back(8'h01);
    run_stream("b2b_80_01", 0, b);
  endtask

  task automatic test_div2();
    bq_t b;
    b.push_back(8'hA3);
    run_stream("div2_A3", 1, b);
  endtask

  task automatic test_three();
    bq_t b;
    for (int i = 0; i < 3; i++) b.push_back(8'($urandom));
    run_stream("three", 0, b);
  endtask

  task automatic test_random();
    bq_t b;
    int  sel, nb;
    for (int it = 0; it < 5; it++) begin
      b.delete();
      sel = $urandom_range(0, 1);
      nb  = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) b.push_back(8'($urandom));
      run_stream("random", sel, b);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
  endtask

  // A byte offered while ready is low must be dropped, not queued.
  task automatic test_ignore();
    logic samp[$];
    bq_t  b;
    int   n, e0, ncyc, badi;
    logic r0;
    b.push_back(8'h3C);
    ncyc = LAT + 10 * DIV1 + 30;
    n = 0; e0 = -1; r0 = 1'b1;
    drive(0, 1'b1, 8'h3C);
    forever begin
      @(negedge clk);
      samp.push_back(tx1);
      if (e0 < 0) begin
        if (rdy1) e0 = n + 1;
      end else if (n == e0 || n == e0 + 30) begin
        if (n == e0) r0 = rdy1;
        if (!rdy1) drive(0, 1'b1, 8'hFF);
        else drive(0, 1'b0, 8'h00);
      end else begin
        drive(0, 1'b0, 8'h00);
      end
      n++;
      if (e0 >= 0 && n >= e0 + ncyc) break;
      if (n > 5000) break;
    end
    checks++;
    if (e0 < 0) begin
      errors++;
      $display("FAIL ignore handshake timeout: accepted=0 required=1");
      return;
    end
    badi = -1;
    for (int i = 0; i < ncyc; i++)
      if (samp[e0 + i] !== model_line(b, DIV1, i - LAT) && badi < 0) badi = i;
    if (badi >= 0) begin
      errors++;
      $display("FAIL ignore line: cycle %0d tx=%b required=%b", badi, samp[e0 + badi], model_line(b, DIV1, badi - LAT));
    end
    checks += 2;
    if (r0 !== 1'b0) begin errors++; $display("FAIL ignore ready busy: got %b required 0", r0); end
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL ignore ready end: got %b required 1", rdy1); end
  endtask

  // Reset asserted mid-frame aborts at once and the line stays idle.
  task automatic test_reset_midframe();
    int n, bad;
    n = 0;
    drive(0, 1'b1, 8'h00);
    @(negedge clk);
    while (!rdy1 && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    repeat (34) @(negedge clk);
    checks++;
    if (tx1 !== 1'b0) begin errors++; $display("FAIL midframe line busy: got %b required 0", tx1); end
    rst = 1'b1;
    #1;
    checks += 2;
    if (tx1 !== 1'b1)  begin errors++; $display("FAIL midframe reset tx: got %b required 1", tx1); end
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL midframe reset ready: got %b required 1", rdy1); end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || rdy1 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midframe after release: %0d non-idle cycles, required 0", bad); end
  endtask

  initial begin
    #1;
    test_reset();
    test_frame_55();
    test_back_to_back();
    test_ignore();
    test_div2();
    test_three();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
